// File: rtl/tof_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tof_stream_sequencer
// Brief    : Captures ToF timestamp frames and streams them word-by-word to a
//            histogram builder over a run of ACQ_NUM acquisitions.
//            Optional inter-acquisition gap: define SEQ_ACQ_GAP_EN.
// Revision : 1.0 - initial release
// ============================================================================

// Defaults for the sizes normally provided by parametersSiFH.vh.
`ifndef Np
`define Np 10
`endif
`ifndef PIXEL_NUM
`define PIXEL_NUM 3
`endif
`ifndef ACQ_NUM
`define ACQ_NUM 2
`endif

module tof_stream_sequencer (
    input  logic                               clk,
    input  logic                               res,
    input  logic                               start,
    input  logic                               hitValid,
    input  logic [`PIXEL_NUM*2*`Np-1:0]        hitData,
    output logic                               ready,
    output logic                               wrEn,
    output logic [`Np-1:0]                     data,
    output logic [$clog2(`ACQ_NUM):0]          acqCnt,
    output logic                               busy,
    output logic                               done
);

    localparam int c_WORDS = 2 * `PIXEL_NUM;
    localparam int c_IDX_W = $clog2(c_WORDS);
    localparam int c_CNT_W = $clog2(`ACQ_NUM) + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_ACQ = c_CNT_W'(`ACQ_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_STREAM = 3'd2,
        S_DONE   = 3'd3
`ifdef SEQ_ACQ_GAP_EN
        ,
        S_GAP    = 3'd4
`endif
    } state_t;

    state_t               r_state;
    logic [`Np-1:0]       r_frame [c_WORDS];
    logic [c_IDX_W-1:0]   r_wordIdx;
`ifdef SEQ_ACQ_GAP_EN
    localparam int c_GAP_CYCLES = 4;
    logic [1:0]           r_gapCnt;
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state   <= S_IDLE;
            r_wordIdx <= '0;
            ready     <= 1'b0;
            wrEn      <= 1'b0;
            data      <= '0;
            acqCnt    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < c_WORDS; i++) begin
                r_frame[i] <= '0;
            end
`ifdef SEQ_ACQ_GAP_EN
            r_gapCnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready     <= 1'b0;
                    wrEn      <= 1'b0;
                    data      <= '0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    acqCnt    <= '0;
                    r_wordIdx <= '0;
                    if (start) begin
                        busy    <= 1'b1;
                        ready   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end

                // Capture only once ready is visible, so a frame is never
                // taken in the cycle ready is still low after a stream.
                S_WAIT: begin
                    wrEn  <= 1'b0;
                    data  <= '0;
                    ready <= 1'b1;
                    if (hitValid && ready) begin
                        for (int i = 0; i < c_WORDS; i++) begin
                            r_frame[i] <= hitData[i*`Np +: `Np];
                        end
                        ready     <= 1'b0;
                        r_wordIdx <= '0;
                        r_state   <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    wrEn <= 1'b1;
                    data <= r_frame[r_wordIdx];
                    if (r_wordIdx == c_LAST_IDX) begin
                        r_wordIdx <= '0;
                        if (acqCnt == c_LAST_ACQ) begin
                            r_state <= S_DONE;
                        end else begin
                            acqCnt  <= acqCnt + c_CNT_W'(1);
`ifdef SEQ_ACQ_GAP_EN
                            r_gapCnt <= '0;
                            r_state  <= S_GAP;
`else
                            r_state  <= S_WAIT;
`endif
                        end
                    end else begin
                        r_wordIdx <= r_wordIdx + c_IDX_W'(1);
                    end
                end

`ifdef SEQ_ACQ_GAP_EN
                S_GAP: begin
                    wrEn  <= 1'b0;
                    data  <= '0;
                    ready <= 1'b0;
                    if (r_gapCnt == 2'(c_GAP_CYCLES - 1)) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_gapCnt <= r_gapCnt + 2'd1;
                    end
                end
`endif

                S_DONE: begin
                    wrEn    <= 1'b0;
                    data    <= '0;
                    ready   <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tof_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tof_stream_sequencer
// Brief    : Scoreboard bench for tof_stream_sequencer; directed frames.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef Np
`define Np 10
`endif
`ifndef PIXEL_NUM
`define PIXEL_NUM 3
`endif
`ifndef ACQ_NUM
`define ACQ_NUM 2
`endif

module tb_tof_stream_sequencer;

    logic                        clk = 1'b0;
    logic                        res;
    logic                        start;
    logic                        hitValid;
    logic [`PIXEL_NUM*2*`Np-1:0] hitData;
    logic                        ready;
    logic                        wrEn;
    logic [`Np-1:0]              data;
    logic [$clog2(`ACQ_NUM):0]   acqCnt;
    logic                        busy;
    logic                        done;

    int nChecks = 0;
    int nBad    = 0;
    logic [`Np-1:0] expQ[$];

    tof_stream_sequencer dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .hitValid (hitValid),
        .hitData  (hitData),
        .ready    (ready),
        .wrEn     (wrEn),
        .data     (data),
        .acqCnt   (acqCnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [`PIXEL_NUM*2*`Np-1:0] pack6(
        input int w0, input int w1, input int w2,
        input int w3, input int w4, input int w5);
        logic [`PIXEL_NUM*2*`Np-1:0] f;
        f = '0;
        f[0*`Np +: `Np] = w0[`Np-1:0];
        f[1*`Np +: `Np] = w1[`Np-1:0];
        f[2*`Np +: `Np] = w2[`Np-1:0];
        f[3*`Np +: `Np] = w3[`Np-1:0];
        f[4*`Np +: `Np] = w4[`Np-1:0];
        f[5*`Np +: `Np] = w5[`Np-1:0];
        return f;
    endfunction

    // Monitor: every written word must match the next scoreboard entry.
    always @(negedge clk) begin
        if (wrEn === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nBad++;
                $display("FAIL stream_extra: unexpected word %0d at %0t", data, $time);
            end else begin
                chk("stream_data", int'(data), int'(expQ.pop_front()));
            end
        end
    end

    // Drives one frame in WAIT and checks the stream timing around it.
    task automatic doFrame(input logic [`PIXEL_NUM*2*`Np-1:0] fr, input int acqAfter,
                           input bit last, input bit inject);
        for (int k = 0; k < 2*`PIXEL_NUM; k++) expQ.push_back(fr[k*`Np +: `Np]);
        hitData  = fr;
        hitValid = 1'b1;
        tick();
        hitValid = 1'b0;
        chk("ready_after_capture", int'(ready), 0);
        chk("wren_at_capture", int'(wrEn), 0);
        for (int i = 0; i < 2*`PIXEL_NUM; i++) begin
            if (inject && i == 1) begin
                hitValid = 1'b1;
                hitData  = pack6(1, 2, 3, 4, 5, 6);
                start    = 1'b1;
            end
            tick();
            hitValid = 1'b0;
            start    = 1'b0;
            chk("wren_streaming", int'(wrEn), 1);
            if (inject && i == 2) chk("acq_start_ignored", int'(acqCnt), acqAfter - 1);
        end
        tick();
        chk("wren_after_frame", int'(wrEn), 0);
        chk("data_after_frame", int'(data), 0);
        if (last) begin
            chk("done_pulse", int'(done), 1);
            tick();
            chk("done_single", int'(done), 0);
            chk("busy_after_run", int'(busy), 0);
            chk("acq_after_run", int'(acqCnt), 0);
            chk("ready_idle", int'(ready), 0);
        end else begin
            chk("acq_incr", int'(acqCnt), acqAfter);
            chk("busy_mid_run", int'(busy), 1);
            chk("done_mid_run", int'(done), 0);
`ifdef SEQ_ACQ_GAP_EN
            chk("gap_ready", int'(ready), 0);
            for (int g = 0; g < 3; g++) begin
                tick();
                chk("gap_ready", int'(ready), 0);
                chk("gap_wren", int'(wrEn), 0);
            end
            tick();
            chk("ready_after_gap", int'(ready), 1);
`else
            chk("ready_after_last", int'(ready), 1);
`endif
        end
    endtask

    initial begin
        res      = 1'b0;
        start    = 1'b0;
        hitValid = 1'b0;
        hitData  = '0;
        repeat (3) tick();
        chk("rst_wren", int'(wrEn), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_acq", int'(acqCnt), 0);
        res = 1'b1;
        tick();

        // Run 1: start together with hitValid in IDLE -> only start acts.
        start    = 1'b1;
        hitValid = 1'b1;
        hitData  = pack6(7, 7, 7, 7, 7, 7);
        tick();
        start    = 1'b0;
        hitValid = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_ready", int'(ready), 1);
        chk("start_acq", int'(acqCnt), 0);
        repeat (2) tick();
        chk("no_capture_in_idle", int'(wrEn), 0);
        doFrame(pack6(108, 511, 1022, 1022, 200, 90), 1, 1'b0, 1'b1);
        doFrame(pack6(300, 500, 50, 1000, 48, 90), 0, 1'b1, 1'b0);
        repeat (3) tick();

        // Run 2: extreme data codes pass through unchanged.
        start = 1'b1;
        tick();
        start = 1'b0;
        doFrame(pack6(0, 1023, 1, 1022, 0, 1023), 1, 1'b0, 1'b0);
        doFrame(pack6(1023, 0, 512, 511, 1023, 0), 0, 1'b1, 1'b0);

        // Run 3: reset while word 3 is on data aborts the frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        hitData  = pack6(11, 22, 33, 44, 55, 66);
        for (int k = 0; k < 4; k++) expQ.push_back(hitData[k*`Np +: `Np]);
        hitValid = 1'b1;
        tick();
        hitValid = 1'b0;
        repeat (4) tick();
        chk("word3_on_data", int'(data), 44);
        res = 1'b0;
        tick();
        res = 1'b1;
        chk("abort_wren", int'(wrEn), 0);
        chk("abort_data", int'(data), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_acq", int'(acqCnt), 0);
        hitValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 9) chk("post_reset_silent", int'(wrEn) + int'(ready) + int'(busy), 0);
        end
        hitValid = 1'b0;
        repeat (2) tick();
        chk("scoreboard_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        nBad++;
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/tof_stream_sequencer.md
TOF_STREAM_SEQUENCER -- requirements
Module: tof_stream_sequencer

Interface
REQ-001 SHALL take compile-time sizes from "parametersSiFH.vh":
- `Np, 10, timestamp code width in bits.
- `PIXEL_NUM, 3, pixels per frame.
- `ACQ_NUM, 2, acquisitions per run.
- Hits per pixel are fixed at 2.
REQ-002 SHALL have one clock and a synchronous, active-low reset. The ports are:
- clk  in  1  single clock; all logic acts on the rising edge.
- res  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run of `ACQ_NUM acquisitions.
- hitValid  in  1  a frame of timestamps is present on hitData.
- hitData  in  `PIXEL_NUM*2*`Np  frame data; word k is at bits [k*`Np +: `Np].
- ready  out  1  the block can accept a frame.
- wrEn  out  1  histogram-builder write enable.
- data  out  `Np  histogram-builder rough timestamp.
- acqCnt  out  $clog2(`ACQ_NUM)+1  index of the current acquisition.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, STREAM, GAP and DONE; every output SHALL be registered.
REQ-004 IDLE: a start pulse SHALL cause the transition to WAIT, set busy=1 and clear acqCnt to 0.
REQ-005 WAIT: ready SHALL be 1.
- When hitValid=1 at an edge, all 2*`PIXEL_NUM words SHALL be captured into an internal frame buffer at that edge.
- The state SHALL change to STREAM and ready SHALL go to 0.
REQ-006 STREAM: SHALL emit one word per cycle with wrEn=1 and no bubbles.
- Word order: pixel0 hit0, pixel0 hit1, pixel1 hit0, ... up to pixel(`PIXEL_NUM-1) hit1.
- The first word SHALL appear one cycle after the capture edge.
REQ-007 Latency: from the hitValid capture edge to the last word is 2*`PIXEL_NUM cycles; the block SHALL then drive wrEn=0 and data=0.
REQ-008 After the last word:
- If acqCnt=`ACQ_NUM-1, the state SHALL go to DONE.
- Otherwise acqCnt SHALL increment and the state SHALL go to GAP, or to WAIT if the gap is compiled out (see REQ-015).
REQ-009 DONE: SHALL assert done=1 for exactly one cycle, then set busy=0, acqCnt=0 and return to IDLE.
REQ-010 Boundary conditions:
- hitValid outside WAIT SHALL be ignored, and the frame buffer SHALL remain unchanged.
- start outside IDLE SHALL be ignored.
- start and hitValid arriving in the same IDLE cycle: only start SHALL take effect.
REQ-011 Data codes, including 0 and all-ones, SHALL pass to the output unmodified; there is no arithmetic on the data.
REQ-012 The internal word index SHALL wrap to 0 at the end of each frame.

Reset
REQ-013 With res=0 at a clock edge, the block SHALL enter IDLE and clear all outputs:
- wrEn=0, data=0, ready=0, busy=0, done=0, acqCnt=0.
- The word index, gap counter and frame buffer SHALL also be cleared.
REQ-014 Reset asserted mid-frame SHALL abort the frame with no further wrEn; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-015 Macro SEQ_ACQ_GAP_EN controls the gap between acquisitions.
- Defined: GAP SHALL hold wrEn=0 and ready=0 for exactly 4 cycles between acquisitions, then enter WAIT.
- Undefined: the GAP state SHALL be absent, and STREAM SHALL go directly to WAIT; ready rises the cycle after the last word.

Verification
REQ-016 Start, then frame {108,511,1022,1022,200,90} -> wrEn=1 for 6 consecutive cycles with data in that order, then ready=1 and acqCnt=1.
REQ-017 Second frame {300,500,50,1000,48,90} -> 6 words streamed, then done=1 for one cycle, then busy=0 and acqCnt=0.
REQ-018 hitValid pulsed with {1,2,3,4,5,6} during STREAM of frame 1 -> stream unchanged (108..90), and the pulse is not captured.
REQ-019 res=0 for one cycle while word 3 is on data -> next cycle wrEn=0, data=0, busy=0; a later hitValid without start produces no output.
REQ-020 With SEQ_ACQ_GAP_EN defined -> exactly 4 cycles of wrEn=0 and ready=0 between acquisitions; undefined -> ready=1 one cycle after the last word.
REQ-021 start pulsed while busy=1 -> no effect on acqCnt or the stream.
